// File: rtl/riscv_alu.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_alu
//  Purpose  : RV32I execute-stage ALU with a registered result and zero flag
//  Revision : 1.0  initial release
// ============================================================================

module riscv_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       alucon,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    localparam logic [3:0] c_op_add   = 4'b0000;
    localparam logic [3:0] c_op_sub   = 4'b0001;
    localparam logic [3:0] c_op_and   = 4'b0010;
    localparam logic [3:0] c_op_or    = 4'b0011;
    localparam logic [3:0] c_op_xor   = 4'b0100;
    localparam logic [3:0] c_op_sll   = 4'b0101;
    localparam logic [3:0] c_op_srl   = 4'b0110;
    localparam logic [3:0] c_op_sra   = 4'b0111;
    localparam logic [3:0] c_op_slt   = 4'b1000;
    localparam logic [3:0] c_op_sltu  = 4'b1001;
    localparam logic [3:0] c_op_passb = 4'b1010;
    localparam logic [3:0] c_op_passa = 4'b1011;

    logic [4:0]       w_shamt;
    logic [WIDTH-1:0] w_result;
    logic             w_lt_signed;
    logic             w_lt_unsigned;

    // Only the low five bits of B form the shift amount; the rest are ignored.
    assign w_shamt       = B[4:0];
    assign w_lt_signed   = $signed(A) < $signed(B);
    assign w_lt_unsigned = A < B;

    always_comb begin
        w_result = '0;
        case (alucon)
            c_op_add:   w_result = A + B;
            c_op_sub:   w_result = A - B;
            c_op_and:   w_result = A & B;
            c_op_or:    w_result = A | B;
            c_op_xor:   w_result = A ^ B;
            c_op_sll:   w_result = A << w_shamt;
            c_op_srl:   w_result = A >> w_shamt;
            c_op_sra:   w_result = $unsigned($signed(A) >>> w_shamt);
            c_op_slt:   w_result = {{(WIDTH-1){1'b0}}, w_lt_signed};
            c_op_sltu:  w_result = {{(WIDTH-1){1'b0}}, w_lt_unsigned};
            c_op_passb: w_result = B;
            c_op_passa: w_result = A;
            default:    w_result = '0;
        endcase
    end

    // Zero flag derives from the same combinational result, so it is
    // always consistent with the value being registered alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out  <= '0;
            zero <= 1'b1;
        end else begin
            out  <= w_result;
            zero <= (w_result == '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_riscv_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_alu
//  Purpose  : directed self-checking bench for riscv_alu
//  Revision : 1.0  initial release
// ============================================================================

module tb_riscv_alu;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  alucon;
    logic [31:0] out;
    logic        zero;

    int n_checks = 0;
    int n_pass   = 0;

    riscv_alu #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .alucon (alucon),
        .out    (out),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Drive one operation, let one rising edge register it, then sample.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [31:0] exp_out, input logic exp_zero);
        A = a; B = b; alucon = op;
        @(posedge clk); #1;
        check({tag, ".out"},  out, exp_out);
        check({tag, ".zero"}, {31'b0, zero}, {31'b0, exp_zero});
    endtask

    initial begin
        reset = 1'b1; A = 32'd5; B = 32'd3; alucon = 4'b0000;
        #2;
        check("rst_async.out",  out, 32'h0);
        check("rst_async.zero", {31'b0, zero}, 32'h1);
        @(posedge clk); #1;
        check("rst_edge.out",  out, 32'h0);
        check("rst_edge.zero", {31'b0, zero}, 32'h1);
        @(posedge clk); #1;
        check("rst_hold.out", out, 32'h0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_rel.out",  out, 32'd8);
        check("rst_rel.zero", {31'b0, zero}, 32'h0);

        run_op("add",   32'd1, 32'd1, 4'b0000, 32'd2, 1'b0);
        run_op("sub",   32'd2, 32'd1, 4'b0001, 32'd1, 1'b0);
        run_op("and",   32'd2, 32'd2, 4'b0010, 32'd2, 1'b0);
        run_op("or",    32'd1, 32'd1, 4'b0011, 32'd1, 1'b0);
        run_op("xor",   32'd1, 32'd1, 4'b0100, 32'd0, 1'b1);
        run_op("sll",   32'd1, 32'd1, 4'b0101, 32'd2, 1'b0);
        run_op("srl",   32'd1, 32'd1, 4'b0110, 32'd0, 1'b1);

        run_op("sub_wrap", 32'h0,        32'd1, 4'b0001, 32'hFFFFFFFF, 1'b0);
        run_op("add_wrap", 32'hFFFFFFFF, 32'd1, 4'b0000, 32'h0,        1'b1);
        run_op("sra_neg",  32'h80000000, 32'd4, 4'b0111, 32'hF8000000, 1'b0);
        run_op("srl_neg",  32'h80000000, 32'd4, 4'b0110, 32'h08000000, 1'b0);
        run_op("sll_mask", 32'd1,        32'h25, 4'b0101, 32'h20,      1'b0);
        run_op("sra_pos",  32'h40000000, 32'd30, 4'b0111, 32'h1,       1'b0);
        run_op("sll_0",    32'hA5A5A5A5, 32'h20, 4'b0101, 32'hA5A5A5A5, 1'b0);
        run_op("sub_ovf",  32'h80000000, 32'd1, 4'b0001, 32'h7FFFFFFF, 1'b0);

        run_op("slt_neg",  32'hFFFFFFFF, 32'd1, 4'b1000, 32'd1, 1'b0);
        run_op("sltu_big", 32'hFFFFFFFF, 32'd1, 4'b1001, 32'd0, 1'b1);
        run_op("slt_eq",   32'd3,        32'd3, 4'b1000, 32'd0, 1'b1);
        run_op("sltu_lt",  32'd1,        32'hFFFFFFFF, 4'b1001, 32'd1, 1'b0);
        run_op("slt_pos",  32'd1,        32'hFFFFFFFF, 4'b1000, 32'd0, 1'b1);

        run_op("passb",  32'h11111111, 32'hDEADBEEF, 4'b1010, 32'hDEADBEEF, 1'b0);
        run_op("passa",  32'h12345678, 32'h22222222, 4'b1011, 32'h12345678, 1'b0);
        run_op("rsv_f",  32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1);
        run_op("rsv_c",  32'h00000007, 32'h00000009, 4'b1100, 32'h0, 1'b1);

        // Mid-stream asynchronous reset between edges.
        run_op("pre_rst", 32'd20, 32'd22, 4'b0000, 32'd42, 1'b0);
        A = 32'h0; B = 32'hDEADBEEF; alucon = 4'b1010;
        #2 reset = 1'b1;
        #1;
        check("mid_rst.out",  out, 32'h0);
        check("mid_rst.zero", {31'b0, zero}, 32'h1);
        @(posedge clk); #1;
        check("mid_hold.out", out, 32'h0);
        A = 32'h0000F0F0; B = 32'h00000FF0; alucon = 4'b0100;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst.out",  out, 32'h0000FF00);
        check("post_rst.zero", {31'b0, zero}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riscv_alu.md
Name: riscv_alu

Overview:
- 32-bit integer ALU for the RISC-V CPU core execute stage.
- Takes two operands and a 4-bit operation select and computes the RV32I arithmetic, logic, shift and compare result.
- Registers the result and a zero flag on the rising clock edge.
- The zero flag feeds branch resolution; the result feeds the memory/writeback path.

Parameters:
- WIDTH, 32, operand/result width in bits; shift amount is always B[4:0] (WIDTH fixed at 32 for RV32).

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- A  input  32  operand A (rs1 / PC)
- B  input  32  operand B (rs2 / immediate)
- alucon  input  4  operation select
- out  output  32  registered result
- zero  output  1  registered flag, 1 when the registered result equals 0

Behaviour:
- Reset: asynchronous, active-high. While reset=1: out=32'h0, zero=1 (consistent with out=0). Reset has priority over any clock edge. Asserting reset mid-operation discards the pending result immediately.
- Latency: result for inputs sampled at rising edge N appears on out/zero after edge N, and holds until the next edge. No handshake; a new operation is accepted every cycle.
- Datapath: combinational result R computed from A, B, alucon, then registered. Registered zero = (R == 0), computed from the same R (not from the previous out).
- alucon encoding:
  - 0000 ADD: A + B, modulo 2^32, carry discarded.
  - 0001 SUB: A - B, modulo 2^32; wraps, e.g. 0 - 1 = FFFFFFFF.
  - 0010 AND: A & B.
  - 0011 OR: A | B.
  - 0100 XOR: A ^ B.
  - 0101 SLL: A << B[4:0].
  - 0110 SRL: A >> B[4:0], zero fill.
  - 0111 SRA: A >>> B[4:0], sign fill from A[31].
  - 1000 SLT: 1 if signed(A) < signed(B), else 0.
  - 1001 SLTU: 1 if unsigned A < unsigned B, else 0.
  - 1010 PASSB: B (LUI).
  - 1011 PASSA: A.
  - 1100–1111: reserved; R = 0, hence zero = 1.
- Shifts use only B[4:0]; B[31:5] are ignored. Shift by 0 returns A unchanged.
- Compare results are zero-extended to 32 bits.
- Overflow is not flagged; signed overflow in ADD/SUB simply wraps.
- Inputs are not registered internally. Behaviour with X/Z inputs is not specified.

Test Plan:
- Reset: assert reset with A=5, B=3, alucon=0000, then clock → out=0, zero=1 throughout reset. Release reset → next edge gives out=8, zero=0.
- Basic ops, one per cycle, each checked one edge later:
  - A=1, B=1, ADD → 2
  - A=2, B=1, SUB → 1
  - A=2, B=2, AND → 2
  - A=1, B=1, OR → 1
  - A=1, B=1, XOR → 0 with zero=1
  - A=1, B=1, SLL → 2
  - A=1, B=1, SRL → 0 with zero=1
- Wrap and sign handling:
  - A=0, B=1, SUB → FFFFFFFF
  - A=FFFFFFFF, B=1, ADD → 0 with zero=1
  - A=80000000, B=4, SRA → F8000000
  - A=80000000, B=4, SRL → 08000000
  - A=1, B=0x25, SLL → 0x20 (only B[4:0] used)
- Compares:
  - A=FFFFFFFF, B=1, SLT → 1
  - A=FFFFFFFF, B=1, SLTU → 0 with zero=1
  - A=3, B=3, SLT → 0
- Pass and reserved:
  - B=DEADBEEF, PASSB → DEADBEEF
  - A=12345678, PASSA → 12345678
  - alucon=1111 with any A/B → out=0, zero=1
- Reset mid-stream: drive back-to-back ops and assert reset asynchronously between edges → out drops to 0 and zero rises to 1 without waiting for a clock edge. Release reset → next edge reflects the current inputs.
